// File: rtl/sccb_req_arbiter.sv
// rtl/sccb_req_arbiter.sv - round-robin arbiter feeding one SCCB transaction engine, with retry and timeout
module sccb_req_arbiter #(
  parameter int          N_REQ      = 3,
  parameter logic [7:0]  SLAVE_ADDR = 8'h42,
  parameter int          MAX_RETRY  = 3,
  parameter int          TIMEOUT_TK = 255
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iTICK,
  input  logic [N_REQ-1:0]     iREQ,
  input  logic [N_REQ-1:0]     iREQ_WR,
  input  logic [16*N_REQ-1:0]  iREQ_DATA,
  output logic [N_REQ-1:0]     oGNT,
  output logic [N_REQ-1:0]     oDONE,
  output logic [N_REQ-1:0]     oERR,
  output logic [7:0]           oRDATA,
  output logic                 oI2C_GO,
  output logic                 oI2C_WR,
  output logic [23:0]          oI2C_DATA,
  input  logic                 iI2C_END,
  input  logic                 iI2C_ACK,
  input  logic [7:0]           iI2C_RDATA
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_BUSY,
    WAIT_END,
    RESP
  } stateT;

  stateT              state;
  stateT              stateNext;

  logic [IDX_W-1:0]   lastIdx;
  logic               hasLast;
  logic [IDX_W-1:0]   curIdx;
  logic               latWr;
  logic               ackOk;
  logic [7:0]         retryCnt;
  logic [7:0]         tickCnt;

  logic               found;
  logic [IDX_W-1:0]   winIdx;
  logic [N_REQ-1:0]   winOh;
  logic               winWr;
  logic [15:0]        winData;
  int                 startI;
  int                 idx;

  logic               tickHit;
  logic               retryLeft;

  logic               ldGrant;
  logic               doLaunch;
  logic               enterEnd;
  logic               tickInc;
  logic               endOk;
  logic               endFail;
  logic               doRetry;
  logic               doFinish;

  assign tickHit   = (tickCnt + 8'd1) == 8'(TIMEOUT_TK);
  assign retryLeft = !ackOk && (retryCnt < 8'(MAX_RETRY));

  // Round-robin search: first requester after the last one served; index 0 first after reset.
  always_comb begin
    found   = 1'b0;
    winIdx  = '0;
    winOh   = '0;
    winWr   = 1'b0;
    winData = '0;
    idx     = 0;
    startI  = hasLast ? ((int'(lastIdx) + 1) % N_REQ) : 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (startI + k) % N_REQ;
      if (!found && iREQ[idx]) begin
        found      = 1'b1;
        winIdx     = IDX_W'(idx);
        winOh[idx] = 1'b1;
        winWr      = iREQ_WR[idx];
        winData    = iREQ_DATA[16*idx +: 16];
      end
    end
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state and datapath strobes; only the completion step runs off-tick.
  always_comb begin
    stateNext = state;
    ldGrant   = 1'b0;
    doLaunch  = 1'b0;
    enterEnd  = 1'b0;
    tickInc   = 1'b0;
    endOk     = 1'b0;
    endFail   = 1'b0;
    doRetry   = 1'b0;
    doFinish  = 1'b0;
    case (state)
      IDLE: begin
        if (iTICK && (|iREQ)) stateNext = ARB;
      end
      ARB: begin
        if (iTICK) begin
          if (found) begin
            stateNext = LAUNCH;
            ldGrant   = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      LAUNCH: begin
        if (iTICK) begin
          stateNext = WAIT_BUSY;
          doLaunch  = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (iTICK) begin
          if (!iI2C_END) begin
            stateNext = WAIT_END;
            enterEnd  = 1'b1;
          end else if (tickHit) begin
            stateNext = RESP;
            endFail   = 1'b1;
          end else begin
            tickInc = 1'b1;
          end
        end
      end
      WAIT_END: begin
        if (iTICK) begin
          if (iI2C_END) begin
            stateNext = RESP;
            endOk     = 1'b1;
          end else if (tickHit) begin
            stateNext = RESP;
            endFail   = 1'b1;
          end else begin
            tickInc = 1'b1;
          end
        end
      end
      RESP: begin
        if (retryLeft) begin
          if (iTICK) begin
            stateNext = LAUNCH;
            doRetry   = 1'b1;
          end
        end else begin
          stateNext = IDLE;
          doFinish  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latched request, engine handshake outputs, counters and completion reporting.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oGNT      <= '0;
      oDONE     <= '0;
      oERR      <= '0;
      oRDATA    <= '0;
      oI2C_GO   <= 1'b0;
      oI2C_WR   <= 1'b0;
      oI2C_DATA <= '0;
      lastIdx   <= '0;
      hasLast   <= 1'b0;
      curIdx    <= '0;
      latWr     <= 1'b0;
      ackOk     <= 1'b0;
      retryCnt  <= '0;
      tickCnt   <= '0;
    end else begin
      oDONE <= '0;
      oERR  <= '0;
      if (ldGrant) begin
        oGNT      <= winOh;
        curIdx    <= winIdx;
        latWr     <= winWr;
        oI2C_DATA <= {SLAVE_ADDR, winData};
        retryCnt  <= '0;
        ackOk     <= 1'b0;
      end
      if (doLaunch) begin
        oI2C_GO <= 1'b1;
        oI2C_WR <= latWr;
        tickCnt <= '0;
      end
      if (enterEnd) tickCnt <= '0;
      if (tickInc)  tickCnt <= tickCnt + 8'd1;
      if (endOk) begin
        oI2C_GO <= 1'b0;
        oI2C_WR <= 1'b0;
        ackOk   <= !iI2C_ACK;
      end
      if (endFail) begin
        oI2C_GO <= 1'b0;
        oI2C_WR <= 1'b0;
        ackOk   <= 1'b0;
      end
      if (doRetry) retryCnt <= retryCnt + 8'd1;
      if (doFinish) begin
        oDONE   <= oGNT;
        oERR    <= ackOk ? '0 : oGNT;
        if (!latWr) oRDATA <= iI2C_RDATA;
        oGNT    <= '0;
        lastIdx <= curIdx;
        hasLast <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// tb/tb_sccb_req_arbiter.sv - directed bench for sccb_req_arbiter with a behavioural SCCB engine
module tb_sccb_req_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iTICK = 1'b0;
  logic [2:0]  iREQ = '0;
  logic [2:0]  iREQ_WR = '0;
  logic [47:0] iREQ_DATA = '0;
  logic [2:0]  oGNT;
  logic [2:0]  oDONE;
  logic [2:0]  oERR;
  logic [7:0]  oRDATA;
  logic        oI2C_GO;
  logic        oI2C_WR;
  logic [23:0] oI2C_DATA;
  logic        iI2C_END = 1'b1;
  logic        iI2C_ACK = 1'b1;
  logic [7:0]  iI2C_RDATA = '0;

  int total = 0;
  int bad = 0;

  int          goCount = 0;
  int          doneCnt = 0;
  int          ohViol = 0;
  int          dblDone = 0;
  int          goTicks = 0;
  int          lastGoTicks = 0;
  logic [2:0]  lastDone = '0;
  logic [2:0]  lastErr = '0;
  logic [7:0]  lastRdata = '0;
  int          doneQ[$];
  logic        prevGo = 1'b0;
  logic [2:0]  prevDone = '0;
  logic [1:0]  tdiv = '0;

  bit          engBusy = 1'b0;
  bit          engNack = 1'b0;
  bit          engStuck = 1'b0;
  int          engCnt = 0;
  logic [23:0] engData = '0;
  logic        engWr = 1'b0;
  logic [2:0]  engGnt = '0;
  logic [7:0]  engRdata = '0;

  sccb_req_arbiter #(
    .N_REQ(3),
    .SLAVE_ADDR(8'h42),
    .MAX_RETRY(3),
    .TIMEOUT_TK(8)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iTICK(iTICK),
    .iREQ(iREQ),
    .iREQ_WR(iREQ_WR),
    .iREQ_DATA(iREQ_DATA),
    .oGNT(oGNT),
    .oDONE(oDONE),
    .oERR(oERR),
    .oRDATA(oRDATA),
    .oI2C_GO(oI2C_GO),
    .oI2C_WR(oI2C_WR),
    .oI2C_DATA(oI2C_DATA),
    .iI2C_END(iI2C_END),
    .iI2C_ACK(iI2C_ACK),
    .iI2C_RDATA(iI2C_RDATA)
  );

  always #5 iCLK = ~iCLK;

  // Output monitor, engine model and tick strobe (one tick every 4 clocks), all on the falling edge.
  always @(negedge iCLK) begin
    if ($countones(oGNT) > 1 || $countones(oDONE) > 1) ohViol++;
    if (oDONE != 3'b000) begin
      doneCnt++;
      lastDone  = oDONE;
      lastErr   = oERR;
      lastRdata = oRDATA;
      for (int i = 0; i < 3; i++) if (oDONE[i]) doneQ.push_back(i);
      if (prevDone != 3'b000) dblDone++;
    end
    if (iTICK && prevGo) goTicks++;
    if (oI2C_GO && !prevGo) begin
      goCount++;
      goTicks = 0;
    end
    if (!oI2C_GO && prevGo) lastGoTicks = goTicks;
    if (engBusy) begin
      engCnt--;
      if (engCnt == 0) begin
        iI2C_END   = 1'b1;
        iI2C_ACK   = engNack;
        iI2C_RDATA = engRdata;
        engBusy    = 1'b0;
      end
    end else if (oI2C_GO && !prevGo && !engStuck) begin
      engBusy  = 1'b1;
      engCnt   = 12;
      iI2C_END = 1'b0;
      engData  = oI2C_DATA;
      engWr    = oI2C_WR;
      engGnt   = oGNT;
    end
    prevGo   = oI2C_GO;
    prevDone = oDONE;
    tdiv     = tdiv + 2'd1;
    iTICK    = (tdiv == 2'd0);
  end

  task automatic wait_done(input int budget, output bit ok);
    int base;
    base = doneCnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge iCLK);
      #1;
      if (doneCnt != base) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    #1;
    total++; if (oGNT !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b want 000", oGNT); end
    total++; if (oDONE !== 3'b000) begin bad++; $display("FAIL reset_done: got %b want 000", oDONE); end
    total++; if (oERR !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", oERR); end
    total++; if (oRDATA !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", oRDATA); end
    total++; if (oI2C_GO !== 1'b0) begin bad++; $display("FAIL reset_go: got %b want 0", oI2C_GO); end
    total++; if (oI2C_WR !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", oI2C_WR); end
    total++; if (oI2C_DATA !== 24'h000000) begin bad++; $display("FAIL reset_data: got %h want 000000", oI2C_DATA); end
    iRST = 1'b0;
  endtask

  task automatic test_contention();
    int exp[4] = '{0, 1, 2, 0};
    int got;
    bit ok;
    iRST = 1'b1;
    @(negedge iCLK);
    #1;
    iRST = 1'b0;
    doneQ.delete();
    ohViol  = 0;
    dblDone = 0;
    iREQ_DATA = {16'h3333, 16'h2222, 16'h1111};
    iREQ_WR   = 3'b111;
    iREQ      = 3'b111;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge iCLK);
      #1;
      if (doneQ.size() >= 4) ok = 1'b1;
    end
    iREQ = 3'b000;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL contention_timeout: got %0d dones want 4", doneQ.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < doneQ.size()) ? doneQ[i] : -1;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, got, exp[i]); end
    end
    total++; if (ohViol !== 0) begin bad++; $display("FAIL contention_onehot: got %0d violations want 0", ohViol); end
    total++; if (dblDone !== 0) begin bad++; $display("FAIL contention_done_width: got %0d long pulses want 0", dblDone); end
    repeat (20) @(negedge iCLK);
  endtask

  task automatic test_single_write();
    int base;
    bit ok;
    base = goCount;
    iREQ_WR = 3'b001;
    iREQ_DATA[15:0] = 16'h1280;
    iREQ = 3'b001;
    wait_done(400, ok);
    iREQ = 3'b000;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL write_timeout: got no done want done"); end
    total++; if (engData !== 24'h421280) begin bad++; $display("FAIL write_data: got %h want 421280", engData); end
    total++; if (engWr !== 1'b1) begin bad++; $display("FAIL write_wr: got %b want 1", engWr); end
    total++; if (engGnt !== 3'b001) begin bad++; $display("FAIL write_gnt: got %b want 001", engGnt); end
    total++; if (lastDone !== 3'b001) begin bad++; $display("FAIL write_done: got %b want 001", lastDone); end
    total++; if (lastErr !== 3'b000) begin bad++; $display("FAIL write_err: got %b want 000", lastErr); end
    total++; if (goCount - base !== 1) begin bad++; $display("FAIL write_go_count: got %0d want 1", goCount - base); end
    repeat (20) @(negedge iCLK);
  endtask

  task automatic test_nack();
    int base;
    bit ok;
    base = goCount;
    engNack = 1'b1;
    iREQ_WR = 3'b010;
    iREQ_DATA[31:16] = 16'h3a05;
    iREQ = 3'b010;
    wait_done(1500, ok);
    iREQ = 3'b000;
    engNack = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL nack_timeout: got no done want done"); end
    total++; if (goCount - base !== 4) begin bad++; $display("FAIL nack_go_count: got %0d want 4", goCount - base); end
    total++; if (lastDone !== 3'b010) begin bad++; $display("FAIL nack_done: got %b want 010", lastDone); end
    total++; if (lastErr !== 3'b010) begin bad++; $display("FAIL nack_err: got %b want 010", lastErr); end
    total++; if (engData !== 24'h423a05) begin bad++; $display("FAIL nack_data: got %h want 423a05", engData); end
    repeat (20) @(negedge iCLK);
  endtask

  task automatic test_timeout();
    int base;
    bit ok;
    base = goCount;
    engStuck = 1'b1;
    iREQ_WR = 3'b100;
    iREQ_DATA[47:32] = 16'h5501;
    iREQ = 3'b100;
    wait_done(2000, ok);
    iREQ = 3'b000;
    engStuck = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL timeout_no_done: got no done want done"); end
    total++; if (goCount - base !== 4) begin bad++; $display("FAIL timeout_go_count: got %0d want 4", goCount - base); end
    total++; if (lastGoTicks !== 8) begin bad++; $display("FAIL timeout_go_ticks: got %0d want 8", lastGoTicks); end
    total++; if (lastDone !== 3'b100) begin bad++; $display("FAIL timeout_done: got %b want 100", lastDone); end
    total++; if (lastErr !== 3'b100) begin bad++; $display("FAIL timeout_err: got %b want 100", lastErr); end
    repeat (20) @(negedge iCLK);
  endtask

  task automatic test_ignore_change();
    bit gntSeen;
    bit ok;
    iREQ_WR = 3'b100;
    iREQ_DATA[47:32] = 16'ha1b2;
    iREQ = 3'b100;
    gntSeen = 1'b0;
    for (int i = 0; i < 200 && !gntSeen; i++) begin
      @(negedge iCLK);
      #1;
      if (oGNT != 3'b000) gntSeen = 1'b1;
    end
    iREQ_DATA[47:32] = 16'hffff;
    iREQ_WR = 3'b000;
    iREQ = 3'b000;
    wait_done(400, ok);
    total++; if (gntSeen !== 1'b1) begin bad++; $display("FAIL ignore_grant: got no grant want grant"); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ignore_done_missing: got no done want done"); end
    total++; if (engData !== 24'h42a1b2) begin bad++; $display("FAIL ignore_data: got %h want 42a1b2", engData); end
    total++; if (engWr !== 1'b1) begin bad++; $display("FAIL ignore_wr: got %b want 1", engWr); end
    total++; if (lastDone !== 3'b100) begin bad++; $display("FAIL ignore_done: got %b want 100", lastDone); end
    repeat (20) @(negedge iCLK);
  endtask

  task automatic test_read();
    bit ok;
    engRdata = 8'h76;
    iREQ_WR = 3'b000;
    iREQ_DATA[15:0] = 16'h0a00;
    iREQ = 3'b001;
    wait_done(400, ok);
    iREQ = 3'b000;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL read_timeout: got no done want done"); end
    total++; if (lastRdata !== 8'h76) begin bad++; $display("FAIL read_rdata: got %h want 76", lastRdata); end
    total++; if (engWr !== 1'b0) begin bad++; $display("FAIL read_wr: got %b want 0", engWr); end
    total++; if (engData !== 24'h420a00) begin bad++; $display("FAIL read_data: got %h want 420a00", engData); end
    total++; if (lastDone !== 3'b001) begin bad++; $display("FAIL read_done: got %b want 001", lastDone); end
    total++; if (lastErr !== 3'b000) begin bad++; $display("FAIL read_err: got %b want 000", lastErr); end
    repeat (20) @(negedge iCLK);
  endtask

  task automatic test_reset_mid();
    int base;
    bit busySeen;
    bit ok;
    iREQ_WR = 3'b010;
    iREQ_DATA[31:16] = 16'h1234;
    iREQ = 3'b010;
    busySeen = 1'b0;
    for (int i = 0; i < 200 && !busySeen; i++) begin
      @(negedge iCLK);
      #1;
      if (engBusy) busySeen = 1'b1;
    end
    repeat (6) @(negedge iCLK);
    #1;
    total++; if (busySeen !== 1'b1) begin bad++; $display("FAIL midrst_engine_start: got idle want busy"); end
    total++; if (oI2C_GO !== 1'b1) begin bad++; $display("FAIL midrst_go_before: got %b want 1", oI2C_GO); end
    base = doneCnt;
    iRST = 1'b1;
    iREQ = 3'b000;
    @(negedge iCLK);
    #1;
    total++; if (oI2C_GO !== 1'b0) begin bad++; $display("FAIL midrst_go: got %b want 0", oI2C_GO); end
    total++; if (oGNT !== 3'b000) begin bad++; $display("FAIL midrst_gnt: got %b want 000", oGNT); end
    total++; if (oI2C_DATA !== 24'h000000) begin bad++; $display("FAIL midrst_data: got %h want 000000", oI2C_DATA); end
    total++; if (oRDATA !== 8'h00) begin bad++; $display("FAIL midrst_rdata: got %h want 00", oRDATA); end
    total++; if (oDONE !== 3'b000) begin bad++; $display("FAIL midrst_done: got %b want 000", oDONE); end
    iRST = 1'b0;
    repeat (40) @(negedge iCLK);
    #1;
    total++; if (doneCnt !== base) begin bad++; $display("FAIL midrst_spurious_done: got %0d want %0d", doneCnt, base); end
    iREQ_WR = 3'b011;
    iREQ_DATA[15:0] = 16'h0101;
    iREQ = 3'b011;
    wait_done(400, ok);
    iREQ = 3'b000;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_after_timeout: got no done want done"); end
    total++; if (lastDone !== 3'b001) begin bad++; $display("FAIL midrst_after_index: got %b want 001", lastDone); end
    repeat (20) @(negedge iCLK);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_nack();
    test_timeout();
    test_ignore_change();
    test_read();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
